// File: rtl/ex_operand_stage.sv
// ID/EX operand stage: registers decoded operands, resolves forwarding,
// drives the ALU, holds the NZVC flags and detects load-use hazards.
module ex_operand_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        id_valid,
    input  logic [63:0] id_da,
    input  logic [63:0] id_db,
    input  logic [63:0] id_imm,
    input  logic [4:0]  id_rn,
    input  logic [4:0]  id_rm,
    input  logic [4:0]  id_rd,
    input  logic        id_alu_src,
    input  logic [2:0]  id_alu_op,
    input  logic        id_set_flags,
    input  logic        id_reg_write,
    input  logic        id_mem_read,
    input  logic        id_mem_write,
    input  logic        flush,
    input  logic        exm_reg_write,
    input  logic [4:0]  exm_rd,
    input  logic [63:0] exm_value,
    input  logic        wb_reg_write,
    input  logic [4:0]  wb_rd,
    input  logic [63:0] wb_value,
    input  logic        alu_negative,
    input  logic        alu_zero,
    input  logic        alu_overflow,
    input  logic        alu_carry_out,
    output logic [63:0] alu_a,
    output logic [63:0] alu_b,
    output logic [2:0]  alu_cntrl,
    output logic [63:0] ex_store_data,
    output logic        ex_valid,
    output logic        ex_reg_write,
    output logic        ex_mem_read,
    output logic        ex_mem_write,
    output logic [4:0]  ex_rd,
    output logic [3:0]  flags,
    output logic        stall
);

    typedef struct packed {
        logic        valid;
        logic [63:0] da;
        logic [63:0] db;
        logic [63:0] imm;
        logic [4:0]  rn;
        logic [4:0]  rm;
        logic [4:0]  rd;
        logic        alu_src;
        logic [2:0]  alu_op;
        logic        set_flags;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
    } id_ex_t;

    id_ex_t      ex_q;
    id_ex_t      ex_d;
    logic [3:0]  flags_q;
    logic [63:0] fwd_n;
    logic [63:0] fwd_m;

    function automatic logic [63:0] fwd(
        input logic [4:0]  r,
        input logic [63:0] d,
        input logic        xw,
        input logic [4:0]  xr,
        input logic [63:0] xv,
        input logic        ww,
        input logic [4:0]  wr,
        input logic [63:0] wv
    );
        logic [63:0] v;
        v = d;
        if (r != 5'd31) begin
            if (xw && xr == r)
                v = xv;
            else if (ww && wr == r)
                v = wv;
        end
        return v;
    endfunction

    // A stalled or flushed slot enters EX as an all-zero bubble
    always_comb begin
        ex_d = '0;
        if (!(flush || stall)) begin
            ex_d.valid     = id_valid;
            ex_d.da        = id_da;
            ex_d.db        = id_db;
            ex_d.imm       = id_imm;
            ex_d.rn        = id_rn;
            ex_d.rm        = id_rm;
            ex_d.rd        = id_rd;
            ex_d.alu_src   = id_alu_src;
            ex_d.alu_op    = id_alu_op;
            ex_d.set_flags = id_set_flags;
            ex_d.reg_write = id_reg_write;
            ex_d.mem_read  = id_mem_read;
            ex_d.mem_write = id_mem_write;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ex_q    <= '0;
            flags_q <= '0;
        end else begin
            ex_q <= ex_d;
            if (ex_q.valid && ex_q.set_flags)
                flags_q <= {alu_negative, alu_zero,
                            alu_overflow, alu_carry_out};
        end
    end

    always_comb begin
        fwd_n = fwd(ex_q.rn, ex_q.da, exm_reg_write, exm_rd,
                    exm_value, wb_reg_write, wb_rd, wb_value);
        fwd_m = fwd(ex_q.rm, ex_q.db, exm_reg_write, exm_rd,
                    exm_value, wb_reg_write, wb_rd, wb_value);
    end

    assign alu_a         = fwd_n;
    assign ex_store_data = fwd_m;
    assign alu_b         = ex_q.alu_src ? ex_q.imm : fwd_m;
    assign alu_cntrl     = ex_q.alu_op;
    assign ex_valid      = ex_q.valid;
    assign ex_reg_write  = ex_q.valid & ex_q.reg_write;
    assign ex_mem_read   = ex_q.valid & ex_q.mem_read;
    assign ex_mem_write  = ex_q.valid & ex_q.mem_write;
    assign ex_rd         = ex_q.rd;
    assign flags         = flags_q;

    assign stall = id_valid & ex_valid & ex_mem_read
                 & (ex_rd != 5'd31)
                 & ((id_rn == ex_rd)
                  | (!id_alu_src & (id_rm == ex_rd))
                  | (id_mem_write & (id_rm == ex_rd)));

endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed bench for ex_operand_stage with a queue of expected EX outputs.
module tb_ex_operand_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid;
    logic [63:0] id_da, id_db, id_imm;
    logic [4:0]  id_rn, id_rm, id_rd;
    logic        id_alu_src;
    logic [2:0]  id_alu_op;
    logic        id_set_flags, id_reg_write;
    logic        id_mem_read, id_mem_write;
    logic        flush;
    logic        exm_reg_write;
    logic [4:0]  exm_rd;
    logic [63:0] exm_value;
    logic        wb_reg_write;
    logic [4:0]  wb_rd;
    logic [63:0] wb_value;
    logic        alu_negative, alu_zero;
    logic        alu_overflow, alu_carry_out;
    logic [63:0] alu_a, alu_b, ex_store_data;
    logic [2:0]  alu_cntrl;
    logic        ex_valid, ex_reg_write;
    logic        ex_mem_read, ex_mem_write;
    logic [4:0]  ex_rd;
    logic [3:0]  flags;
    logic        stall;

    int checks = 0;
    int errors = 0;
    logic [3:0] exp_flags;

    typedef struct packed {
        logic        v;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] sd;
        logic [2:0]  c;
        logic [4:0]  rd;
        logic        rw;
        logic        mr;
        logic        mw;
    } exp_t;

    exp_t sb[$];
    exp_t bubble;

    ex_operand_stage dut (
        .clk(clk), .reset(reset), .id_valid(id_valid),
        .id_da(id_da), .id_db(id_db), .id_imm(id_imm),
        .id_rn(id_rn), .id_rm(id_rm), .id_rd(id_rd),
        .id_alu_src(id_alu_src), .id_alu_op(id_alu_op),
        .id_set_flags(id_set_flags), .id_reg_write(id_reg_write),
        .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .flush(flush),
        .exm_reg_write(exm_reg_write), .exm_rd(exm_rd),
        .exm_value(exm_value),
        .wb_reg_write(wb_reg_write), .wb_rd(wb_rd),
        .wb_value(wb_value),
        .alu_negative(alu_negative), .alu_zero(alu_zero),
        .alu_overflow(alu_overflow), .alu_carry_out(alu_carry_out),
        .alu_a(alu_a), .alu_b(alu_b), .alu_cntrl(alu_cntrl),
        .ex_store_data(ex_store_data), .ex_valid(ex_valid),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_rd(ex_rd),
        .flags(flags), .stall(stall)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(
        input logic v, input logic [63:0] a, b, sd,
        input logic [2:0] c, input logic [4:0] rd,
        input logic rw, mr, mw
    );
        exp_t e;
        e = '{v, a, b, sd, c, rd, rw, mr, mw};
        return e;
    endfunction

    task automatic chk(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic drive(
        input logic v, input logic [63:0] da, db, imm,
        input logic [4:0] rn, rm, rd, input logic src,
        input logic [2:0] op, input logic sf, rw, mr, mw
    );
        id_valid = v; id_da = da; id_db = db; id_imm = imm;
        id_rn = rn; id_rm = rm; id_rd = rd;
        id_alu_src = src; id_alu_op = op;
        id_set_flags = sf; id_reg_write = rw;
        id_mem_read = mr; id_mem_write = mw;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0);
    endtask

    task automatic step(input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s: scoreboard empty", tag);
        end else begin
            e = sb.pop_front();
            chk({tag, ".valid"}, 64'(ex_valid), 64'(e.v));
            chk({tag, ".a"}, alu_a, e.a);
            chk({tag, ".b"}, alu_b, e.b);
            chk({tag, ".sd"}, ex_store_data, e.sd);
            chk({tag, ".cntrl"}, 64'(alu_cntrl), 64'(e.c));
            chk({tag, ".rd"}, 64'(ex_rd), 64'(e.rd));
            chk({tag, ".rw"}, 64'(ex_reg_write), 64'(e.rw));
            chk({tag, ".mr"}, 64'(ex_mem_read), 64'(e.mr));
            chk({tag, ".mw"}, 64'(ex_mem_write), 64'(e.mw));
        end
        chk({tag, ".flags"}, 64'(flags), 64'(exp_flags));
    endtask

    initial begin
        bubble = '0;
        exp_flags = 4'b0000;
        reset = 1'b0;
        flush = 1'b0;
        exm_reg_write = 0; exm_rd = 0; exm_value = 0;
        wb_reg_write = 0; wb_rd = 0; wb_value = 0;
        alu_negative = 0; alu_zero = 0;
        alu_overflow = 0; alu_carry_out = 0;
        idle();

        sb.push_back(bubble); step("rst0");
        sb.push_back(bubble); step("rst1");
        chk("rst.stall", 64'(stall), 64'd0);
        reset = 1'b1;

        // ADDS X1,X2,X3
        drive(1, 64'd5, -64'sd5, 0, 2, 3, 1, 0, 3'b010, 1, 1, 0, 0);
        sb.push_back(mk(1, 64'd5, -64'sd5, -64'sd5,
                        3'b010, 1, 1, 0, 0));
        step("adds");
        alu_zero = 1; alu_carry_out = 1;
        idle();
        exp_flags = 4'b0101;
        sb.push_back(bubble); step("adds_fl");
        alu_negative = 1; alu_zero = 0; alu_carry_out = 0;

        // forwarding priority
        exm_reg_write = 1; exm_rd = 4; exm_value = 64'h11;
        wb_reg_write = 1; wb_rd = 4; wb_value = 64'h22;
        drive(1, 64'hAAAA, 64'hBBBB, 0, 4, 4, 10, 0,
              3'b010, 0, 1, 0, 0);
        sb.push_back(mk(1, 64'h11, 64'h11, 64'h11,
                        3'b010, 10, 1, 0, 0));
        step("fwd_exm");
        exm_reg_write = 0;
        #1;
        chk("fwd_wb.a", alu_a, 64'h22);
        chk("fwd_wb.b", alu_b, 64'h22);
        chk("fwd_wb.sd", ex_store_data, 64'h22);
        exm_reg_write = 1; exm_rd = 31; wb_rd = 31;
        drive(1, 64'h33, 64'h44, 0, 31, 31, 11, 0,
              3'b010, 0, 1, 0, 0);
        sb.push_back(mk(1, 64'h33, 64'h44, 64'h44,
                        3'b010, 11, 1, 0, 0));
        step("fwd_xzr");
        exm_reg_write = 0; exm_rd = 0;
        wb_reg_write = 0; wb_rd = 0;

        // load-use on Rn
        drive(1, 64'h100, 0, 64'd8, 1, 0, 7, 1, 3'b010, 0, 1, 1, 0);
        sb.push_back(mk(1, 64'h100, 64'd8, 0, 3'b010, 7, 1, 1, 0));
        step("ldur");
        drive(1, 64'hDEAD, 64'd3, 0, 7, 2, 8, 0, 3'b010, 0, 1, 0, 0);
        #1;
        chk("lu.stall", 64'(stall), 64'd1);
        sb.push_back(bubble); step("lu_bub");
        chk("lu.release", 64'(stall), 64'd0);
        wb_reg_write = 1; wb_rd = 7; wb_value = 64'h777;
        sb.push_back(mk(1, 64'h777, 64'd3, 64'd3,
                        3'b010, 8, 1, 0, 0));
        step("lu_add");
        chk("lu_add.stall", 64'(stall), 64'd0);
        wb_reg_write = 0; wb_rd = 0; wb_value = 0;

        // store data hazard, immediate form, with flush
        drive(1, 64'h100, 0, 64'd8, 1, 0, 7, 1, 3'b010, 0, 1, 1, 0);
        sb.push_back(mk(1, 64'h100, 64'd8, 0, 3'b010, 7, 1, 1, 0));
        step("ldur2");
        drive(1, 64'h100, 64'h5, 64'd7, 1, 7, 9, 1,
              3'b010, 0, 1, 0, 0);
        #1;
        chk("addi.stall", 64'(stall), 64'd0);
        drive(1, 64'h100, 64'h5, 0, 1, 7, 0, 1, 3'b010, 0, 0, 0, 1);
        #1;
        chk("stur.stall", 64'(stall), 64'd1);
        flush = 1;
        #1;
        chk("stur_fl.stall", 64'(stall), 64'd1);
        sb.push_back(bubble); step("stur_fl");
        flush = 0;
        sb.push_back(mk(1, 64'h100, 0, 64'h5, 3'b010, 0, 0, 0, 1));
        step("stur");

        // flushed SUBS must not touch flags
        alu_negative = 1; alu_overflow = 1;
        flush = 1;
        drive(1, 64'd9, 64'd4, 0, 1, 2, 3, 0, 3'b011, 1, 1, 0, 0);
        sb.push_back(bubble); step("flush");
        flush = 0;
        idle();
        sb.push_back(bubble); step("post_fl");

        // immediate operand select
        drive(1, 64'h12, 64'h99, 64'h40, 3, 4, 5, 1,
              3'b010, 0, 1, 0, 0);
        sb.push_back(mk(1, 64'h12, 64'h40, 64'h99,
                        3'b010, 5, 1, 0, 0));
        step("imm");

        // reset while stalled
        drive(1, 64'h100, 0, 64'd8, 1, 0, 7, 1, 3'b010, 0, 1, 1, 0);
        sb.push_back(mk(1, 64'h100, 64'd8, 0, 3'b010, 7, 1, 1, 0));
        step("ldur3");
        drive(1, 64'hDEAD, 64'd3, 0, 7, 2, 8, 0, 3'b010, 0, 1, 0, 0);
        #1;
        chk("ldur3.stall", 64'(stall), 64'd1);
        reset = 0;
        exp_flags = 4'b0000;
        sb.push_back(bubble); step("rst_stall");
        chk("rst_stall.stall", 64'(stall), 64'd0);
        reset = 1;
        idle();
        chk("sb.empty", 64'(sb.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
